turf_udp_tx_arbiter: RTL and testbench
======================================

Name: turf_udp_tx_arbiter

Overview:
Shares the single outbound UDP transmit path (header stream plus payload stream) between NUM_PORTS UDP port blocks. Examples are the event control port, the event data port and housekeeping ports.
Round-robin arbitration at packet granularity: a granted requester owns the path from its header beat through the payload beat carrying tlast.
Sits between the per-port blocks and the UDP/IP transmit engine.

Parameters:
NUM_PORTS, 4, number of requesters (2..8).
PORT_BITS, $clog2(NUM_PORTS), grant index width (derived, not overridden).

Ports:
aclk  in  1  single clock; all logic is synchronous to it.
aresetn  in  1  reset, asynchronous assert, active-low.
s_udphdr_tdata  in  64*NUM_PORTS  per-requester header beat {ip[31:0], port[15:0], length[15:0]}, requester i at [64*i +: 64].
s_udphdr_tvalid  in  NUM_PORTS  per-requester header valid.
s_udphdr_tready  out  NUM_PORTS  per-requester header ready.
s_udpdata_tdata  in  64*NUM_PORTS  per-requester payload data.
s_udpdata_tkeep  in  8*NUM_PORTS  per-requester byte enables.
s_udpdata_tlast  in  NUM_PORTS  per-requester end of packet.
s_udpdata_tvalid  in  NUM_PORTS  per-requester payload valid.
s_udpdata_tready  out  NUM_PORTS  per-requester payload ready.
m_udphdr_tdata  out  64  header to the transmit engine.
m_udphdr_tvalid  out  1  header valid.
m_udphdr_tready  in  1  header ready.
m_udpdata_tdata  out  64  payload data.
m_udpdata_tkeep  out  8  payload byte enables.
m_udpdata_tlast  out  1  payload end of packet.
m_udpdata_tvalid  out  1  payload valid.
m_udpdata_tready  in  1  payload ready.
port_enable_i  in  NUM_PORTS  requester i is eligible only while bit i=1.
grant_o  out  PORT_BITS  current or most recent grant index.
busy_o  out  1  high in HDR or DATA states.

Behaviour:
- Asynchronous reset (aresetn=0) immediately sets:
  - state=IDLE, last_grant=NUM_PORTS-1 (so port 0 wins first), grant_o=0, busy_o=0.
  - All tready and tvalid outputs 0; m_* data, keep and last outputs 0.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - req = s_udphdr_tvalid & port_enable_i.
  - If req≠0, grant = first set bit of req searching upward from last_grant+1, wrapping modulo NUM_PORTS. Register grant and go to HDR on the next edge.
  - No ready is asserted in IDLE. Arbitration costs one cycle.
- HDR:
  - m_udphdr_tdata = s_udphdr_tdata[grant]; m_udphdr_tvalid = s_udphdr_tvalid[grant]; s_udphdr_tready[grant] = m_udphdr_tready.
  - All other requesters' readies are 0. Pass-through is combinational with zero latency.
  - On the beat where m_udphdr_tvalid and m_udphdr_tready are both high, go to DATA.
- DATA:
  - m_udpdata_* = s_udpdata_*[grant]; s_udpdata_tready[grant] = m_udpdata_tready.
  - On a handshake beat with tlast=1: last_grant <= grant, go to IDLE.
  - A single-beat packet (tlast on the first beat) is legal.
- Outside the matching state, every m_* valid is 0 and every s_* ready is 0. A header is never forwarded during DATA, and payload is never forwarded during HDR.
- Disabling a requester (port_enable_i bit going 0) mid-packet does not revoke the grant. Enable is sampled only in IDLE.
- Requester i presenting payload before its header is granted sees ready=0; nothing is dropped.
- With a single continuous requester, back-to-back packets are separated by exactly one IDLE cycle.
- With all requesters continuously requesting, grants rotate 0,1,2,...,NUM_PORTS-1,0.
- Mid-packet reset: the packet is abandoned, outputs drop asynchronously, and arbitration restarts at port 0. The downstream engine handles the truncated packet.
- grant_o holds its value through IDLE until the next grant.

Decomposition:
- Shared package turf_udp_pkg holds:
  - UDP_DATA_W=64, UDP_KEEP_W=8.
  - Header field offsets: IP [63:32], PORT [31:16], LEN [15:0].
  - FSM state typedef.
- One natural sub-module: rr_priority_select (combinational).
  - Inputs: req[NUM_PORTS-1:0], last[PORT_BITS-1:0].
  - Outputs: grant index and a valid flag.
  - It is reused by later schedulers.

Test Plan:
- Reset then port0 sends hdr 64'h0A00_0001_1234_0010 plus 2 payload beats (tlast on beat 2) -> m_udphdr_tdata matches; m_udpdata carries both beats; busy_o falls the cycle after tlast; grant_o=0.
- Ports 0-3 all hold continuous 1-beat packets -> grant order 0,1,2,3,0,1; each packet's header plus data appears contiguous; no interleaving.
- Port2 in DATA while m_udpdata_tready is held 0 for 5 cycles and port1 requests -> port2's data is held stable, s_udpdata_tready[1]=0 throughout, and port1 is granted only after port2's tlast.
- port_enable_i=4'b1101 with port1 requesting alone -> never granted; clearing enable 0 mid-packet still completes port0's packet.
- aresetn asserted mid-DATA on port3 -> all valids and readies 0 in the same cycle; after release, a request on ports 0 and 3 grants 0 first.
- Single port with back-to-back 1-beat packets and tready=1 -> exactly one IDLE cycle between packets (3-cycle period).

Source files
------------

// File: rtl/turf_udp_pkg.sv
// turf_udp_pkg: shared widths, UDP header layout and the
// transmit-arbiter state encoding for the TURF UDP path.
package turf_udp_pkg;

  localparam int UDP_DATA_W = 64;
  localparam int UDP_KEEP_W = 8;

  localparam int UDP_HDR_IP_LSB   = 32;
  localparam int UDP_HDR_IP_W     = 32;
  localparam int UDP_HDR_PORT_LSB = 16;
  localparam int UDP_HDR_PORT_W   = 16;
  localparam int UDP_HDR_LEN_LSB  = 0;
  localparam int UDP_HDR_LEN_W    = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HDR,
    ARB_DATA
  } arb_state_t;

  function automatic logic [UDP_HDR_LEN_W-1:0] udp_hdr_len(
    input logic [UDP_DATA_W-1:0] hdr
  );
    return hdr[UDP_HDR_LEN_LSB +: UDP_HDR_LEN_W];
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: round-robin pick of the first set request
// bit above 'last', wrapping modulo NUM_PORTS. Purely combinational.
module rr_priority_select #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_BITS-1:0] last,
  output logic [PORT_BITS-1:0] grant,
  output logic                 valid
);

  logic [PORT_BITS-1:0] idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = PORT_BITS'((int'(last) + k) % NUM_PORTS);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turf_udp_tx_arbiter.sv
// turf_udp_tx_arbiter: packet-granular round-robin share of the
// outbound UDP header + payload streams among NUM_PORTS requesters.
module turf_udp_tx_arbiter
  import turf_udp_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [UDP_DATA_W*NUM_PORTS-1:0]  s_udphdr_tdata,
  input  logic [NUM_PORTS-1:0]             s_udphdr_tvalid,
  output logic [NUM_PORTS-1:0]             s_udphdr_tready,
  input  logic [UDP_DATA_W*NUM_PORTS-1:0]  s_udpdata_tdata,
  input  logic [UDP_KEEP_W*NUM_PORTS-1:0]  s_udpdata_tkeep,
  input  logic [NUM_PORTS-1:0]             s_udpdata_tlast,
  input  logic [NUM_PORTS-1:0]             s_udpdata_tvalid,
  output logic [NUM_PORTS-1:0]             s_udpdata_tready,
  output logic [UDP_DATA_W-1:0]            m_udphdr_tdata,
  output logic                             m_udphdr_tvalid,
  input  logic                             m_udphdr_tready,
  output logic [UDP_DATA_W-1:0]            m_udpdata_tdata,
  output logic [UDP_KEEP_W-1:0]            m_udpdata_tkeep,
  output logic                             m_udpdata_tlast,
  output logic                             m_udpdata_tvalid,
  input  logic                             m_udpdata_tready,
  input  logic [NUM_PORTS-1:0]             port_enable_i,
  output logic [PORT_BITS-1:0]             grant_o,
  output logic                             busy_o
);

  arb_state_t           state_q, state_d;
  logic [PORT_BITS-1:0] grant_q, grant_d;
  logic [PORT_BITS-1:0] last_q, last_d;
  logic [PORT_BITS-1:0] sel_grant;
  logic                 sel_valid;
  logic [NUM_PORTS-1:0] req;
  logic                 hdr_fire;
  logic                 data_fire;

  logic [UDP_DATA_W-1:0] hdr_a  [NUM_PORTS];
  logic [UDP_DATA_W-1:0] data_a [NUM_PORTS];
  logic [UDP_KEEP_W-1:0] keep_a [NUM_PORTS];

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      hdr_a[i]  = s_udphdr_tdata[UDP_DATA_W*i +: UDP_DATA_W];
      data_a[i] = s_udpdata_tdata[UDP_DATA_W*i +: UDP_DATA_W];
      keep_a[i] = s_udpdata_tkeep[UDP_KEEP_W*i +: UDP_KEEP_W];
    end
  end

  // Enable only matters while choosing; an owner keeps the path.
  assign req = s_udphdr_tvalid & port_enable_i;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_sel (
    .req   (req),
    .last  (last_q),
    .grant (sel_grant),
    .valid (sel_valid)
  );

  always_comb begin
    m_udphdr_tdata   = '0;
    m_udphdr_tvalid  = 1'b0;
    s_udphdr_tready  = '0;
    m_udpdata_tdata  = '0;
    m_udpdata_tkeep  = '0;
    m_udpdata_tlast  = 1'b0;
    m_udpdata_tvalid = 1'b0;
    s_udpdata_tready = '0;
    unique case (state_q)
      ARB_HDR: begin
        m_udphdr_tdata           = hdr_a[grant_q];
        m_udphdr_tvalid          = s_udphdr_tvalid[grant_q];
        s_udphdr_tready[grant_q] = m_udphdr_tready;
      end
      ARB_DATA: begin
        m_udpdata_tdata           = data_a[grant_q];
        m_udpdata_tkeep           = keep_a[grant_q];
        m_udpdata_tlast           = s_udpdata_tlast[grant_q];
        m_udpdata_tvalid          = s_udpdata_tvalid[grant_q];
        s_udpdata_tready[grant_q] = m_udpdata_tready;
      end
      default: ;
    endcase
  end

  assign hdr_fire  = m_udphdr_tvalid & m_udphdr_tready;
  assign data_fire = m_udpdata_tvalid & m_udpdata_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (sel_valid) begin
          grant_d = sel_grant;
          state_d = ARB_HDR;
        end
      end
      ARB_HDR: begin
        if (hdr_fire) state_d = ARB_DATA;
      end
      ARB_DATA: begin
        if (data_fire && m_udpdata_tlast) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // last_q resets to the top index so port 0 is first in line.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= PORT_BITS'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_turf_udp_tx_arbiter.sv
// tb_turf_udp_tx_arbiter: directed scenarios plus randomized traffic,
// checked each cycle against a packet-level round-robin model.
module tb_turf_udp_tx_arbiter;

  localparam int N  = 4;
  localparam int PB = 2;

  typedef struct packed {
    logic [63:0] hdr;
    logic [31:0] pid;
    logic [7:0]  nbeats;
  } pkt_t;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [64*N-1:0] s_udphdr_tdata = '0;
  logic [N-1:0]    s_udphdr_tvalid = '0;
  logic [N-1:0]    s_udphdr_tready;
  logic [64*N-1:0] s_udpdata_tdata = '0;
  logic [8*N-1:0]  s_udpdata_tkeep = '0;
  logic [N-1:0]    s_udpdata_tlast = '0;
  logic [N-1:0]    s_udpdata_tvalid = '0;
  logic [N-1:0]    s_udpdata_tready;
  logic [63:0]     m_udphdr_tdata;
  logic            m_udphdr_tvalid;
  logic            m_udphdr_tready = 1'b0;
  logic [63:0]     m_udpdata_tdata;
  logic [7:0]      m_udpdata_tkeep;
  logic            m_udpdata_tlast;
  logic            m_udpdata_tvalid;
  logic            m_udpdata_tready = 1'b0;
  logic [N-1:0]    port_enable_i = '1;
  logic [PB-1:0]   grant_o;
  logic            busy_o;

  turf_udp_tx_arbiter #(.NUM_PORTS(N)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_udphdr_tdata   (s_udphdr_tdata),
    .s_udphdr_tvalid  (s_udphdr_tvalid),
    .s_udphdr_tready  (s_udphdr_tready),
    .s_udpdata_tdata  (s_udpdata_tdata),
    .s_udpdata_tkeep  (s_udpdata_tkeep),
    .s_udpdata_tlast  (s_udpdata_tlast),
    .s_udpdata_tvalid (s_udpdata_tvalid),
    .s_udpdata_tready (s_udpdata_tready),
    .m_udphdr_tdata   (m_udphdr_tdata),
    .m_udphdr_tvalid  (m_udphdr_tvalid),
    .m_udphdr_tready  (m_udphdr_tready),
    .m_udpdata_tdata  (m_udpdata_tdata),
    .m_udpdata_tkeep  (m_udpdata_tkeep),
    .m_udpdata_tlast  (m_udpdata_tlast),
    .m_udpdata_tvalid (m_udpdata_tvalid),
    .m_udpdata_tready (m_udpdata_tready),
    .port_enable_i    (port_enable_i),
    .grant_o          (grant_o),
    .busy_o           (busy_o)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int dprob = 100;
  int hrdy = 100;
  int drdy = 100;
  logic [N-1:0] en = '1;
  pkt_t pq [N][$];
  bit   hsent [N];
  int   bidx [N];
  int   md_phase = 0;
  int   md_owner = 0;
  int   md_last = N - 1;
  int   glog[$];
  int   hlog[$];
  int   cyc = 0;
  bit   prev_busy = 0;
  int   pid_ctr = 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [31:0] pid,
                                            input int b);
    return {pid ^ 32'hC0DE_0000, 32'(b)};
  endfunction

  function automatic bit pending();
    for (int p = 0; p < N; p++) if (pq[p].size() != 0) return 1;
    return 0;
  endfunction

  task automatic add_pkt(input int p, input logic [63:0] hdr,
                         input int nb, output int pid);
    pkt_t k;
    k.hdr = hdr;
    k.pid = 32'(pid_ctr);
    k.nbeats = 8'(nb);
    pid = pid_ctr;
    pid_ctr++;
    pq[p].push_back(k);
  endtask

  task automatic cycle();
    logic [N-1:0] hv, dv, dl, hr, dr, req;
    logic [63:0] hd [N];
    logic [63:0] dd [N];
    logic [7:0]  dk [N];
    int o;
    bit found;
    @(negedge aclk);
    for (int p = 0; p < N; p++) begin
      hv[p] = 0; dv[p] = 0; dl[p] = 0;
      hd[p] = '0; dd[p] = '0; dk[p] = '0;
      if (pq[p].size() != 0) begin
        hv[p] = !hsent[p];
        hd[p] = pq[p][0].hdr;
        dv[p] = ($urandom_range(99) < dprob);
        dd[p] = beat_data(pq[p][0].pid, bidx[p]);
        dl[p] = (bidx[p] == int'(pq[p][0].nbeats) - 1);
        dk[p] = dl[p] ? (pq[p][0].pid[7:0] | 8'h01) : 8'hFF;
      end
      s_udphdr_tdata[64*p +: 64]  = hd[p];
      s_udpdata_tdata[64*p +: 64] = dd[p];
      s_udpdata_tkeep[8*p +: 8]   = dk[p];
    end
    s_udphdr_tvalid  = hv;
    s_udpdata_tvalid = dv;
    s_udpdata_tlast  = dl;
    port_enable_i    = en;
    m_udphdr_tready  = ($urandom_range(99) < hrdy);
    m_udpdata_tready = ($urandom_range(99) < drdy);
    #1;
    o = md_owner;
    hr = '0;
    dr = '0;
    if (md_phase == 1) hr[o] = m_udphdr_tready;
    if (md_phase == 2) dr[o] = m_udpdata_tready;
    chk("busy", busy_o, md_phase != 0);
    chk("grant", grant_o, o);
    chk("hdr_valid", m_udphdr_tvalid, md_phase == 1 && hv[o]);
    chk("hdr_data", m_udphdr_tdata, md_phase == 1 ? hd[o] : 64'h0);
    chk("hdr_ready", s_udphdr_tready, hr);
    chk("data_valid", m_udpdata_tvalid, md_phase == 2 && dv[o]);
    chk("data", m_udpdata_tdata, md_phase == 2 ? dd[o] : 64'h0);
    chk("keep", m_udpdata_tkeep, md_phase == 2 ? dk[o] : 8'h0);
    chk("last", m_udpdata_tlast, md_phase == 2 && dl[o]);
    chk("data_ready", s_udpdata_tready, dr);
    cyc++;
    if (busy_o && !prev_busy) glog.push_back(int'(grant_o));
    prev_busy = busy_o;
    if (m_udphdr_tvalid && m_udphdr_tready) hlog.push_back(cyc);
    // Sources react to the readies they actually saw.
    for (int p = 0; p < N; p++) begin
      if (hv[p] && s_udphdr_tready[p]) hsent[p] = 1;
      if (dv[p] && s_udpdata_tready[p] && pq[p].size() != 0) begin
        if (dl[p]) begin
          pq[p].delete(0);
          hsent[p] = 0;
          bidx[p] = 0;
        end else begin
          bidx[p]++;
        end
      end
    end
    case (md_phase)
      0: begin
        req = hv & en;
        if (req != '0) begin
          found = 0;
          for (int k = 1; k <= N; k++) begin
            if (!found && req[(md_last + k) % N]) begin
              md_owner = (md_last + k) % N;
              found = 1;
            end
          end
          md_phase = 1;
        end
      end
      1: if (hv[o] && m_udphdr_tready) md_phase = 2;
      default: begin
        if (dv[o] && m_udpdata_tready && dl[o]) begin
          md_phase = 0;
          md_last = o;
        end
      end
    endcase
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_hvalid", m_udphdr_tvalid, 0);
    chk("rst_dvalid", m_udpdata_tvalid, 0);
    chk("rst_hready", s_udphdr_tready, 0);
    chk("rst_dready", s_udpdata_tready, 0);
    chk("rst_hdata", m_udphdr_tdata, 0);
    chk("rst_data", m_udpdata_tdata, 0);
    chk("rst_keep", m_udpdata_tkeep, 0);
    chk("rst_last", m_udpdata_tlast, 0);
    for (int p = 0; p < N; p++) begin
      if (hsent[p]) pq[p].delete(0);
      hsent[p] = 0;
      bidx[p] = 0;
    end
    md_phase = 0;
    md_owner = 0;
    md_last = N - 1;
    prev_busy = 0;
    s_udphdr_tvalid = '0;
    s_udpdata_tvalid = '0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (pending() && n < bound) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    chk(tag, pending(), 0);
  endtask

  task automatic run_to_data(input string tag);
    int n = 0;
    while (md_phase != 2 && n < 30) begin
      cycle();
      n++;
    end
    chk(tag, busy_o, 1);
  endtask

  initial begin
    int pid;
    int pid2;
    for (int p = 0; p < N; p++) begin
      hsent[p] = 0;
      bidx[p] = 0;
    end
    apply_reset();

    // Single two-beat packet from port 0.
    glog.delete();
    add_pkt(0, 64'h0A00_0001_1234_0010, 2, pid);
    drain("t1_drain", 30);
    chk("t1_ngrant", glog.size(), 1);
    if (glog.size() > 0) chk("t1_grant", glog[0], 0);

    // All ports busy: rotation 0..3 twice.
    apply_reset();
    glog.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++)
        add_pkt(p, {$urandom, $urandom}, 1, pid);
    drain("t2_drain", 100);
    chk("t2_ngrant", glog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < glog.size()) chk("t2_order", glog[i], i % N);

    // Port 2 stalled downstream while port 1 waits.
    glog.delete();
    drdy = 0;
    add_pkt(2, {$urandom, $urandom}, 3, pid2);
    run_to_data("t3_p2_data");
    add_pkt(1, {$urandom, $urandom}, 1, pid);
    repeat (5) begin
      cycle();
      chk("t3_hold", m_udpdata_tdata, beat_data(32'(pid2), 0));
      chk("t3_p1_ready", s_udpdata_tready[1], 0);
      chk("t3_p1_hready", s_udphdr_tready[1], 0);
    end
    drdy = 100;
    drain("t3_drain", 50);
    chk("t3_ngrant", glog.size(), 2);
    if (glog.size() > 1) begin
      chk("t3_first", glog[0], 2);
      chk("t3_second", glog[1], 1);
    end

    // Enable masking: port 1 blocked; port 0 survives mid-packet disable.
    glog.delete();
    en = 4'b1101;
    add_pkt(1, {$urandom, $urandom}, 1, pid);
    repeat (10) cycle();
    chk("t4_p1_blocked", glog.size(), 0);
    add_pkt(0, {$urandom, $urandom}, 3, pid);
    run_to_data("t4_p0_data");
    en = 4'b1100;
    for (int n = 0; n < 20 && pq[0].size() != 0; n++) cycle();
    chk("t4_p0_done", pq[0].size(), 0);
    chk("t4_only_p0", glog.size(), 1);
    if (glog.size() > 0) chk("t4_grant0", glog[0], 0);
    en = '1;
    drain("t4_drain", 30);

    // Reset in the middle of a port 3 payload.
    drdy = 0;
    add_pkt(3, {$urandom, $urandom}, 4, pid);
    run_to_data("t5_p3_data");
    cycle();
    apply_reset();
    drdy = 100;
    glog.delete();
    add_pkt(0, {$urandom, $urandom}, 1, pid);
    add_pkt(3, {$urandom, $urandom}, 1, pid);
    drain("t5_drain", 30);
    chk("t5_ngrant", glog.size(), 2);
    if (glog.size() > 1) begin
      chk("t5_first", glog[0], 0);
      chk("t5_second", glog[1], 3);
    end

    // Single requester: one idle cycle between packets.
    hlog.delete();
    for (int i = 0; i < 4; i++) add_pkt(0, {$urandom, $urandom}, 1, pid);
    drain("t6_drain", 40);
    chk("t6_nhdr", hlog.size(), 4);
    for (int i = 1; i < 4; i++)
      if (i < hlog.size()) chk("t6_period", hlog[i] - hlog[i-1], 3);

    // Randomized traffic, enables and backpressure.
    hrdy = 70;
    drdy = 70;
    dprob = 70;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99) < 8) begin
        int p = $urandom_range(N - 1);
        if (pq[p].size() < 3)
          add_pkt(p, {$urandom, $urandom}, $urandom_range(1, 4), pid);
      end
      if (c % 100 == 0) en = N'($urandom);
      cycle();
    end
    en = '1;
    hrdy = 100;
    drdy = 100;
    dprob = 100;
    drain("rand_drain", 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
